concat_scheduler: RTL
=====================

Name: concat_scheduler

Overview:
- Read-side sequencer for channel concatenation. Pops CHANNEL_NUM-word pixel bursts from NUMBER_CONCAT_CHANNELS external per-source FIFOs in fixed order (source 0 first) and emits one concatenated stream with sop/eop/sof/eof.
- Sits between the per-branch convolution output FIFOs and the next layer's input, such as max_pool. Stalls at pixel granularity on downstream backpressure and never underflows a source.

Parameters:
DATA_WIDTH, 8, width of one signed channel word
NUMBER_CONCAT_CHANNELS, 2, number of sources concatenated (at least 2)
CHANNEL_NUM, 8, words per pixel per source (at least 2)
PIXELS_PER_FRAME, 224*224, pixels per frame; used for sof/eof generation

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
clear_i  in  1  synchronous abort; counters and FSM return to ARM
src_avail_i  in  NUMBER_CONCAT_CHANNELS  per source: FIFO holds at least CHANNEL_NUM words
src_rd_o  out  NUMBER_CONCAT_CHANNELS  per-source pop strobe (one-hot or zero)
src_data_i  in  DATA_WIDTH x NUMBER_CONCAT_CHANNELS  FIFO q outputs, valid 1 cycle after pop
dn_ready_i  in  1  downstream can accept one more full concatenated pixel
data_o  out  DATA_WIDTH  concatenated word (signed)
data_valid_o  out  1  data_o valid
sop_o / eop_o  out  1 each  first / last word of concatenated pixel
sof_o / eof_o  out  1 each  first / last word of frame
busy_o  out  1  FSM in BURST
frame_done_o  out  1  one-cycle pulse coincident with eof_o

Behaviour:
- Reset (async, active-high). All outputs 0. FSM=IDLE. src_idx, beat_cnt and pix_cnt are 0. Pipeline valid bits are 0.
- IDLE: go to ARM on the first cycle after reset deasserts.
- ARM: src_rd_o=0.
  - When all src_avail_i bits are 1 and dn_ready_i=1, go to BURST with src_idx=0 and beat_cnt=0.
  - The check is evaluated only at pixel boundaries. Sources may not lose availability except through our pops.
- BURST:
  - src_rd_o[src_idx]=1 every cycle; beat_cnt increments each cycle.
  - When beat_cnt=CHANNEL_NUM-1 and src_idx is less than N-1: src_idx increments and beat_cnt resets to 0. There is no gap cycle between sources.
  - When beat_cnt=CHANNEL_NUM-1 and src_idx=N-1 (pixel end):
    - pix_cnt increments, wrapping to 0 at PIXELS_PER_FRAME-1.
    - If all src_avail_i bits are 1 and dn_ready_i=1 in that same cycle, restart BURST at src_idx=0 with no bubble. Otherwise go to ARM.
- A pixel burst, once started, always completes: N*CHANNEL_NUM consecutive pops. dn_ready_i is ignored mid-burst; downstream must reserve a full pixel of space.
- Output pipeline, 2-cycle latency from pop to data_o:
  - Stage 1 registers valid, src_idx and flags alongside the FIFO read.
  - Stage 2 registers data_o = src_data_i[stage-1 src_idx], valid and flags.
- Flags on the output word:
  - sop_o when src=0 and beat=0.
  - eop_o when src=N-1 and beat=CHANNEL_NUM-1.
  - sof_o = sop_o when pix_cnt=0.
  - eof_o = eop_o when pix_cnt=PIXELS_PER_FRAME-1.
  - frame_done_o = eof_o.
- clear_i:
  - Overrides everything except reset. FSM goes to ARM; src_idx, beat_cnt and pix_cnt go to 0; src_rd_o is 0 the same cycle; pipeline valid bits are flushed.
  - Words popped but not yet emitted are discarded. The source FIFOs are flushed externally.
- A reset asserted mid-burst behaves as clear_i but asynchronously. No partial pixel is emitted afterwards.
- Counter widths are $clog2 of each bound. All comparisons are against parameter-1, so no overflow is possible.

Decomposition:
- Package concat_pkg: FSM state enum {IDLE, ARM, BURST}; flag struct {sop, eop, sof, eof}; function clog2_min1 so that 1-wide counters stay legal.
- Sub-module concat_out_pipe: the 2-stage valid/flag/data pipeline with flush input. It is reusable by concat_channels-style blocks.

Test Plan:
- N=2, CH=8, PIX=4; all avail and ready held at 1 → 64 contiguous data_valid_o beats. Pops run src0 ×8 then src1 ×8 per pixel. sop_o on beats 0, 16, 32, 48; eop_o on beats 15, 31, 47, 63; sof_o on beat 0; eof_o and frame_done_o on beat 63. First data_o arrives 2 cycles after the first pop.
- src_avail_i[1]=0 for 5 cycles in ARM → no pops at all. The first pop of src0 comes 1 cycle after avail[1] rises.
- dn_ready_i drops at beat 3 of pixel 1 → the pixel still completes all 16 pops. The next pixel waits in ARM until ready returns.
- clear_i pulsed at pixel 2, src1, beat 4 → src_rd_o=0 that cycle and no valid output the next 2 cycles. The next burst emits sop_o with sof_o=1, since pix_cnt=0.
- Two back-to-back frames with continuous avail → eof_o on word 63 and sof_o on word 64 with no bubble. pix_cnt wraps to 0.
- Reset asserted mid-burst → all outputs 0 immediately (async). After release: IDLE→ARM, and the first output word has sof_o=1.

Source files
------------

// File: rtl/concat_pkg.sv
// Shared types and helpers for the channel-concatenation read sequencer
// and its output pipeline.
package concat_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARM   = 2'd1,
    BURST = 2'd2
  } state_e;

  typedef struct packed {
    logic sop;
    logic eop;
    logic sof;
    logic eof;
  } flags_t;

  // Counter width for a bound; never below one bit so degenerate bounds still elaborate.
  function automatic int clog2_min1(input int value);
    int w;
    w = $clog2(value);
    if (w < 1) begin
      w = 1;
    end
    return w;
  endfunction

endpackage

// File: rtl/concat_out_pipe.sv
// Two-stage pop-to-output pipeline: stage 1 follows the FIFO pop, stage 2
// captures the selected FIFO q word. flush_i drops everything in flight.
module concat_out_pipe
  import concat_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int NUM_SRC    = 2,
  parameter int SRC_W      = 1
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               flush_i,
  input  logic                               pop_valid_i,
  input  logic [SRC_W-1:0]                   pop_src_i,
  input  flags_t                             pop_flags_i,
  input  logic [NUM_SRC-1:0][DATA_WIDTH-1:0] src_data_i,
  output logic signed [DATA_WIDTH-1:0]       data_o,
  output logic                               data_valid_o,
  output flags_t                             flags_o
);

  logic                         s1_valid_q, s1_valid_d;
  logic [SRC_W-1:0]             s1_src_q, s1_src_d;
  flags_t                       s1_flags_q, s1_flags_d;
  logic                         s2_valid_q, s2_valid_d;
  logic signed [DATA_WIDTH-1:0] s2_data_q, s2_data_d;
  flags_t                       s2_flags_q, s2_flags_d;

  // Next-state for both stages; idle slots carry zero data and flags.
  always_comb begin
    s1_valid_d = 1'b0;
    s1_src_d   = '0;
    s1_flags_d = '0;
    s2_valid_d = 1'b0;
    s2_data_d  = '0;
    s2_flags_d = '0;
    if (flush_i) begin
      s1_valid_d = 1'b0;
      s2_valid_d = 1'b0;
    end else begin
      s1_valid_d = pop_valid_i;
      s1_src_d   = pop_src_i;
      if (pop_valid_i) begin
        s1_flags_d = pop_flags_i;
      end else begin
        s1_flags_d = '0;
      end
      s2_valid_d = s1_valid_q;
      // FIFO q is valid the cycle after the pop, which is exactly when stage 1 holds it.
      if (s1_valid_q) begin
        s2_data_d  = src_data_i[s1_src_q];
        s2_flags_d = s1_flags_q;
      end else begin
        s2_data_d  = '0;
        s2_flags_d = '0;
      end
    end
  end

  // Pipeline registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_valid_q <= 1'b0;
      s1_src_q   <= '0;
      s1_flags_q <= '0;
      s2_valid_q <= 1'b0;
      s2_data_q  <= '0;
      s2_flags_q <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_src_q   <= s1_src_d;
      s1_flags_q <= s1_flags_d;
      s2_valid_q <= s2_valid_d;
      s2_data_q  <= s2_data_d;
      s2_flags_q <= s2_flags_d;
    end
  end

  assign data_o       = s2_data_q;
  assign data_valid_o = s2_valid_q;
  assign flags_o      = s2_flags_q;

endmodule

// File: rtl/concat_scheduler.sv
// Read-side sequencer for channel concatenation: pops one pixel burst from each
// source FIFO in order and emits a single framed stream two cycles later.
module concat_scheduler
  import concat_pkg::*;
#(
  parameter int DATA_WIDTH             = 8,
  parameter int NUMBER_CONCAT_CHANNELS = 2,
  parameter int CHANNEL_NUM            = 8,
  parameter int PIXELS_PER_FRAME       = 224*224
) (
  input  logic                                              clk,
  input  logic                                              reset,
  input  logic                                              clear_i,
  input  logic [NUMBER_CONCAT_CHANNELS-1:0]                 src_avail_i,
  output logic [NUMBER_CONCAT_CHANNELS-1:0]                 src_rd_o,
  input  logic [NUMBER_CONCAT_CHANNELS-1:0][DATA_WIDTH-1:0] src_data_i,
  input  logic                                              dn_ready_i,
  output logic signed [DATA_WIDTH-1:0]                      data_o,
  output logic                                              data_valid_o,
  output logic                                              sop_o,
  output logic                                              eop_o,
  output logic                                              sof_o,
  output logic                                              eof_o,
  output logic                                              busy_o,
  output logic                                              frame_done_o
);

  localparam int SRC_W  = clog2_min1(NUMBER_CONCAT_CHANNELS);
  localparam int BEAT_W = clog2_min1(CHANNEL_NUM);
  localparam int PIX_W  = clog2_min1(PIXELS_PER_FRAME);

  localparam logic [SRC_W-1:0]  SRC_LAST  = SRC_W'(NUMBER_CONCAT_CHANNELS - 1);
  localparam logic [BEAT_W-1:0] BEAT_LAST = BEAT_W'(CHANNEL_NUM - 1);
  localparam logic [PIX_W-1:0]  PIX_LAST  = PIX_W'(PIXELS_PER_FRAME - 1);
  localparam logic [NUMBER_CONCAT_CHANNELS-1:0] SRC0_ONEHOT = NUMBER_CONCAT_CHANNELS'(1);

  state_e            state_q, state_d;
  logic [SRC_W-1:0]  src_idx_q, src_idx_d;
  logic [BEAT_W-1:0] beat_cnt_q, beat_cnt_d;
  logic [PIX_W-1:0]  pix_cnt_q, pix_cnt_d;

  logic                              start_ok_s;
  logic                              beat_last_s;
  logic                              src_last_s;
  logic                              pix_last_s;
  logic [NUMBER_CONCAT_CHANNELS-1:0] src_rd_s;
  logic                              pop_valid_s;
  flags_t                            pop_flags_s;
  flags_t                            out_flags_s;

  assign start_ok_s  = (&src_avail_i) & dn_ready_i;
  assign beat_last_s = (beat_cnt_q == BEAT_LAST);
  assign src_last_s  = (src_idx_q == SRC_LAST);
  assign pix_last_s  = (pix_cnt_q == PIX_LAST);

  // Sequencer next-state: ARM waits for a full pixel of data and space, BURST pops back-to-back.
  always_comb begin
    state_d     = state_q;
    src_idx_d   = src_idx_q;
    beat_cnt_d  = beat_cnt_q;
    pix_cnt_d   = pix_cnt_q;
    src_rd_s    = '0;
    pop_valid_s = 1'b0;
    if (clear_i) begin
      state_d    = ARM;
      src_idx_d  = '0;
      beat_cnt_d = '0;
      pix_cnt_d  = '0;
    end else begin
      case (state_q)
        IDLE: begin
          state_d = ARM;
        end
        ARM: begin
          if (start_ok_s) begin
            state_d    = BURST;
            src_idx_d  = '0;
            beat_cnt_d = '0;
          end else begin
            state_d = ARM;
          end
        end
        BURST: begin
          src_rd_s    = SRC0_ONEHOT << src_idx_q;
          pop_valid_s = 1'b1;
          if (beat_last_s) begin
            beat_cnt_d = '0;
            if (src_last_s) begin
              src_idx_d = '0;
              if (pix_last_s) begin
                pix_cnt_d = '0;
              end else begin
                pix_cnt_d = pix_cnt_q + PIX_W'(1);
              end
              // Pixel boundary: restart without a bubble when the next pixel is ready.
              if (start_ok_s) begin
                state_d = BURST;
              end else begin
                state_d = ARM;
              end
            end else begin
              src_idx_d = src_idx_q + SRC_W'(1);
            end
          end else begin
            beat_cnt_d = beat_cnt_q + BEAT_W'(1);
          end
        end
        default: begin
          state_d    = ARM;
          src_idx_d  = '0;
          beat_cnt_d = '0;
          pix_cnt_d  = '0;
        end
      endcase
    end
  end

  // Framing flags for the word being popped this cycle.
  always_comb begin
    pop_flags_s     = '0;
    pop_flags_s.sop = (src_idx_q == SRC_W'(0)) && (beat_cnt_q == BEAT_W'(0));
    pop_flags_s.eop = src_last_s && beat_last_s;
    pop_flags_s.sof = pop_flags_s.sop && (pix_cnt_q == PIX_W'(0));
    pop_flags_s.eof = pop_flags_s.eop && pix_last_s;
  end

  // Sequencer state and counters.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      src_idx_q  <= '0;
      beat_cnt_q <= '0;
      pix_cnt_q  <= '0;
    end else begin
      state_q    <= state_d;
      src_idx_q  <= src_idx_d;
      beat_cnt_q <= beat_cnt_d;
      pix_cnt_q  <= pix_cnt_d;
    end
  end

  concat_out_pipe #(
    .DATA_WIDTH (DATA_WIDTH),
    .NUM_SRC    (NUMBER_CONCAT_CHANNELS),
    .SRC_W      (SRC_W)
  ) u_out_pipe (
    .clk          (clk),
    .reset        (reset),
    .flush_i      (clear_i),
    .pop_valid_i  (pop_valid_s),
    .pop_src_i    (src_idx_q),
    .pop_flags_i  (pop_flags_s),
    .src_data_i   (src_data_i),
    .data_o       (data_o),
    .data_valid_o (data_valid_o),
    .flags_o      (out_flags_s)
  );

  assign src_rd_o     = src_rd_s;
  assign busy_o       = (state_q == BURST);
  assign sop_o        = out_flags_s.sop;
  assign eop_o        = out_flags_s.eop;
  assign sof_o        = out_flags_s.sof;
  assign eof_o        = out_flags_s.eof;
  assign frame_done_o = out_flags_s.eof;

endmodule
